inv_sub_bytes_iter: RTL and testbench

INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

---
 rtl/inv_sub_bytes_iter.sv | 107 ++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES inverse S-boxes sweep the state low byte first,
// result after 16/LANES cycles, valid/ready handshake on both sides.
module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  // Rows listed from entry 0x00 upward, so entry x sits at packed element ~x.
  localparam logic [255:0][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y_o = INV_TBL[~a_i];
endmodule

module inv_sub_bytes_iter #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam int         WORDS    = 16 / LANES;
  localparam int         WW       = 8 * LANES;
  localparam logic [3:0] LAST_IDX = 4'(16 - LANES);
  localparam logic [3:0] IDX_STEP = 4'(LANES);  // LANES=16 wraps to 0

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic [WORDS-1:0][WW-1:0]   work_q, work_d;
  logic [WW-1:0]              sb_in, sb_out;

  always_comb begin
    sb_in = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == 4'(w * LANES)) sb_in = work_q[w];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .a_i (sb_in[8*l +: 8]),
      .y_o (sb_out[8*l +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          idx_d   = 4'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == 4'(w * LANES)) work_d[w] = sb_out;
        end
        idx_d = idx_q + IDX_STEP;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_state = work_q;
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: LANES=1 directed cases plus LANES=1/4/16 back-to-back
// runs, scored against a forward S-box model.
module tb_inv_sub_bytes_iter;
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           pend  [3];
  logic [7:0]   inv_m [256];

  inv_sub_bytes_iter #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]));
  inv_sub_bytes_iter #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]));
  inv_sub_bytes_iter #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int i = 0; i < 256; i++) inv_m[SBOX[~8'(i)]] = 8'(i);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fwd(input logic [127:0] p);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[~p[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_m[s[8*i +: 8]];
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Per-DUT scoreboard: push the model result on acceptance, pop on output handshake.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic [127:0] exp_q [$];
    int           acc_q [$];
    initial begin
      logic [127:0] e;
      int           a;
      logic         prev_ov;
      prev_ov = 1'b0;
      pend[g] = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_q.delete();
          acc_q.delete();
          prev_ov = 1'b0;
        end else begin
          if (out_valid[g] && !prev_ov) begin
            if (acc_q.size() == 0) begin
              chk($sformatf("unexpected_out%0d", g), 128'(out_valid[g]), 128'd0);
            end else begin
              a = acc_q.pop_front();
              chk($sformatf("latency%0d", g), 128'(cyc - a), 128'(lat_of(g)));
            end
          end
          if (out_valid[g] && out_ready[g]) begin
            if (exp_q.size() == 0) begin
              chk($sformatf("unexpected_hs%0d", g), 128'(out_valid[g]), 128'd0);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("data%0d", g), out_state[g], e);
            end
          end
          if (in_valid[g] && in_ready[g]) begin
            exp_q.push_back(inv_model(in_state[g]));
            acc_q.push_back(cyc + 1);
          end
          prev_ov = out_valid[g];
        end
        pend[g] = exp_q.size();
      end
    end
  end

  task automatic send(input int k, input logic [127:0] s);
    int n;
    n = 0;
    in_state[k] = s;
    in_valid[k] = 1'b1;
    @(negedge clk);
    while (!in_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) chk($sformatf("send_timeout%0d", k), 128'(in_ready[k]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[k]) chk($sformatf("out_timeout%0d", k), 128'(out_valid[k]), 128'd1);
  endtask

  task automatic run1(input string tag, input logic [127:0] s, input logic [127:0] e);
    send(0, s);
    wait_out(0);
    chk(tag, out_state[0], e);
    @(posedge clk);
    #1;
  endtask

  task automatic regress(input int k);
    int t_prev;
    int t_now;
    t_prev = -1;
    for (int n = 0; n < 6; n++) begin
      send(k, fwd(rnd128()));
      t_now = cyc;
      if (t_prev >= 0) chk($sformatf("throughput%0d", k), 128'(t_now - t_prev), 128'(lat_of(k) + 2));
      t_prev = t_now;
    end
  endtask

  initial begin
    logic [127:0] p;
    logic [127:0] s;
    logic [127:0] e;
    int           n;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      out_ready[k] = 1'b1;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready%0d", k), 128'(in_ready[k]), 128'd1);
      chk($sformatf("rst_out_valid%0d", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("rst_out_state%0d", k), out_state[k], 128'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    run1("all63", {16{8'h63}}, 128'd0);
    run1("spot", {{11{8'h63}}, 8'hed, 8'h52, 8'h00, 8'h16, 8'h7c},
         {88'd0, 8'h53, 8'h48, 8'h52, 8'hff, 8'h01});

    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        s[8*i +: 8] = SBOX[~8'(16 * j + i)];
        e[8*i +: 8] = 8'(16 * j + i);
      end
      run1($sformatf("sweep%0d", j), s, e);
    end

    // Consumer stalls for 10 cycles in DONE.
    p = rnd128();
    out_ready[0] = 1'b0;
    send(0, fwd(p));
    wait_out(0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 128'(out_valid[0]), 128'd1);
      chk("stall_in_ready", 128'(in_ready[0]), 128'd0);
      chk("stall_state", out_state[0], p);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_idle", 128'(in_ready[0]), 128'd1);
    chk("release_valid", 128'(out_valid[0]), 128'd0);

    // Reset during the 7th BUSY cycle, then accept on the first edge after release.
    @(posedge clk);
    #1;
    send(0, fwd(rnd128()));
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst_state", out_state[0], 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    p = rnd128();
    in_state[0] = fwd(p);
    in_valid[0] = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    wait_out(0);
    chk("post_rst_result", out_state[0], p);
    @(posedge clk);
    #1;

    // Inputs churn while BUSY; result must follow the captured state.
    p = rnd128();
    send(0, fwd(p));
    for (int i = 0; i < 12; i++) begin
      in_valid[0] = 1'($urandom);
      in_state[0] = rnd128();
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    wait_out(0);
    chk("busy_churn", out_state[0], p);
    @(posedge clk);
    #1;

    fork
      regress(0);
      regress(1);
      regress(2);
    join

    n = 0;
    @(negedge clk);
    while (n < 200 && !(pend[0] == 0 && pend[1] == 0 && pend[2] == 0 &&
                        in_ready[0] && in_ready[1] && in_ready[2])) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("drained%0d", k), 128'(pend[k]), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
